rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between the WB stage and an auxiliary multi-cycle writer (second write of SWP, future mul/div unit).
- WB writes always win and are never delayed. Auxiliary writes are buffered in a small FIFO and drained into idle WB slots.
- Flags ID-stage reads of registers with buffered writes, so the hazard unit can stall.
- Forces a pipeline bubble when the auxiliary queue is starved.

Parameters:
- DEPTH, 4, auxiliary FIFO entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may be blocked by WB before stall_req asserts
- DATA_W, 32, write data width
- ADDR_W, 5, register index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_en  in  1  WB stage write request
- wb_dest  in  ADDR_W  WB destination register
- wb_data  in  DATA_W  WB write data
- aux_valid  in  1  auxiliary write offered
- aux_ready  out  1  FIFO can accept this cycle
- aux_dest  in  ADDR_W  auxiliary destination
- aux_data  in  DATA_W  auxiliary data
- id_src1  in  ADDR_W  ID-stage source 1 index
- id_src2  in  ADDR_W  ID-stage source 2 index
- rf_we  out  1  register-file write enable
- rf_dest  out  ADDR_W  register-file write index
- rf_data  out  DATA_W  register-file write data
- raw_hazard  out  1  ID source matches a buffered auxiliary dest
- stall_req  out  1  request one pipeline bubble (ORed into freeze)
- fifo_count  out  clog2(DEPTH+1)  occupancy

Behaviour:
- Single clock, rst synchronous active-high. Reset empties the FIFO (pointers=0, count=0) and clears the starvation counter and stall_req.
- rf_we and raw_hazard follow the empty FIFO, so they are 0 while reset is held. If wb_en is asserted during reset, the write passes through.
- Mid-operation reset discards all buffered entries with no writes.
- Push: aux_valid & aux_ready pushes {aux_dest, aux_data} at the clock edge. aux_ready = (count != DEPTH), taken from registered count. There is no same-cycle bypass, so minimum aux-to-rf latency is 1 cycle.
- Port mux, combinational, the regfile samples it on the same edge:
  - wb_en=1: rf_we=1, rf_dest=wb_dest, rf_data=wb_data; FIFO holds.
  - wb_en=0 and FIFO non-empty: drive the FIFO head and pop it.
  - Otherwise rf_we=0; rf_dest and rf_data are don't-care, driven from the head.
- Head with dest 0: popped whenever wb_en=0, with rf_we=0; the R0 write is discarded.
- Simultaneous push and pop: count unchanged and both pointers advance. When full, a pop does not raise aux_ready in the same cycle.
- Pointers wrap modulo DEPTH.
- raw_hazard = 1 when any valid FIFO entry has a nonzero dest equal to id_src1 or id_src2. Entries at or beyond count are ignored. An entry being popped this cycle still counts.
- WAW ordering between WB and auxiliary writes to the same register is the issuer's responsibility. The arbiter imposes no ordering.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and wb_en=1.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- stall_req FSM, states IDLE and STALL:
  - IDLE -> STALL when the counter reaches STARVE_LIMIT. stall_req is registered and is 1 in STALL.
  - STALL -> IDLE on the first pop.
  - STALL -> IDLE when the FIFO goes empty by reset.
- fifo_count is the registered occupancy.

Decomposition:
- Shared package: register-index width, data width, R0 index constant, and the stall FSM state typedef {IDLE, STALL}.
- One sub-module, aux_write_fifo: storage, pointers, count, and per-entry dest/valid vectors for the hazard comparators.
- The arbiter top holds the mux, the comparators, the starvation counter and the FSM.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with wb_en=0 -> rf_we=0, aux_ready=1, fifo_count=0, stall_req=0, raw_hazard=0.
- WB priority: push aux (dest 7, 0xAAAA0001) while wb_en=1 (dest 3, 0x55) for 3 cycles -> rf_dest=3 each cycle; then wb_en=0 -> next cycle rf_we=1, rf_dest=7, rf_data=0xAAAA0001, count 1->0.
- Full/wrap: push 4 entries with wb_en=1 -> aux_ready=0 at count=4, a 5th push is rejected. Then drain with wb_en=0 -> four writes in push order; 6 further push/drain rounds to exercise pointer wrap.
- Hazard: FIFO holds dest 9, id_src1=9 -> raw_hazard=1. id_src2=9 -> raw_hazard=1. Dest-0 entry with id_src1=0 -> raw_hazard=0, and it is popped with rf_we=0.
- Starvation: 1 entry, wb_en=1 for 8 cycles -> stall_req=1 from the following cycle. wb_en=0 -> pop occurs, stall_req=0 the next cycle.
- Reset mid-operation: 3 entries buffered, stall_req=1, then rst for 1 cycle -> count=0, stall_req=0, and no buffered entry is ever written.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
package rf_write_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  // Writes to R0 are architecturally discarded.
  localparam logic [ADDR_W_DEF-1:0] R0_IDX = '0;

  typedef enum logic {
    IDLE,
    STALL
  } stall_state_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus between the pipeline (WB, aux writer, ID, hazard unit) and the arbiter.
interface rf_write_arbiter_if
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              wb_en;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;

  logic              aux_valid;
  logic              aux_ready;
  logic [ADDR_W-1:0] aux_dest;
  logic [DATA_W-1:0] aux_data;

  logic [ADDR_W-1:0] id_src1;
  logic [ADDR_W-1:0] id_src2;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_dest;
  logic [DATA_W-1:0] rf_data;

  logic              raw_hazard;
  logic              stall_req;
  logic [CNT_W-1:0]  fifo_count;

  // Pipeline side.
  modport master (
    output wb_en, wb_dest, wb_data,
    output aux_valid, aux_dest, aux_data,
    output id_src1, id_src2,
    input  aux_ready, rf_we, rf_dest, rf_data,
    input  raw_hazard, stall_req, fifo_count
  );

  // Arbiter side.
  modport slave (
    input  wb_en, wb_dest, wb_data,
    input  aux_valid, aux_dest, aux_data,
    input  id_src1, id_src2,
    output aux_ready, rf_we, rf_dest, rf_data,
    output raw_hazard, stall_req, fifo_count
  );

endinterface

// File: rtl/rf_write_arbiter_fifo.sv
// Auxiliary write buffer: circular storage with per-entry dest/valid taps.
module aux_write_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [ADDR_W-1:0]             push_dest,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop,
  output logic [ADDR_W-1:0]             head_dest,
  output logic [DATA_W-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          empty,
  output logic [DEPTH-1:0][ADDR_W-1:0]  entry_dest,
  output logic [DEPTH-1:0]              entry_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][ADDR_W-1:0] dest_mem;
  logic [DATA_W-1:0]            data_mem [DEPTH];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             offset;

  assign empty      = (count == '0);
  assign head_dest  = dest_mem[rd_ptr];
  assign head_data  = data_mem[rd_ptr];
  assign entry_dest = dest_mem;

  // Entry storage; contents need no reset since validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_mem[wr_ptr] <= push_dest;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    entry_valid = '0;
    offset      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset         = PTR_W'(i) - rd_ptr;
      entry_valid[i] = (CNT_W'(offset) < count);
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: WB priority, buffered aux writes,
// RAW hazard flagging against buffered writes and starvation stall request.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  rf_write_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] R0 = ADDR_W'(R0_IDX);

  logic [ADDR_W-1:0]            head_dest;
  logic [DATA_W-1:0]            head_data;
  logic [CNT_W-1:0]             count;
  logic                         empty;
  logic [DEPTH-1:0][ADDR_W-1:0] entry_dest;
  logic [DEPTH-1:0]             entry_valid;

  logic                         aux_ready;
  logic                         push;
  logic                         pop;
  logic                         hazard;
  logic [STV_W-1:0]             starve_cnt;
  logic [STV_W-1:0]             starve_next;
  stall_state_t                 state;

  assign aux_ready = (count != CNT_W'(DEPTH));
  assign push      = bus.aux_valid & aux_ready;
  // No draining while reset is held so buffered entries are discarded unwritten.
  assign pop       = ~rst & ~bus.wb_en & ~empty;

  aux_write_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_dest   (bus.aux_dest),
    .push_data   (bus.aux_data),
    .pop         (pop),
    .head_dest   (head_dest),
    .head_data   (head_data),
    .count       (count),
    .empty       (empty),
    .entry_dest  (entry_dest),
    .entry_valid (entry_valid)
  );

  assign bus.aux_ready  = aux_ready;
  assign bus.fifo_count = count;
  assign bus.rf_we      = bus.wb_en | (pop & (head_dest != R0));
  assign bus.rf_dest    = bus.wb_en ? bus.wb_dest : head_dest;
  assign bus.rf_data    = bus.wb_en ? bus.wb_data : head_data;
  assign bus.raw_hazard = hazard & ~rst;

  // Compare both ID sources against every live, non-R0 buffered destination.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_dest[i] != R0) &&
          ((entry_dest[i] == bus.id_src1) || (entry_dest[i] == bus.id_src2))) begin
        hazard = 1'b1;
      end
    end
  end

  // Next starvation count: cleared by a pop or an empty FIFO, saturating otherwise.
  always_comb begin
    starve_next = starve_cnt;
    if (pop || empty) begin
      starve_next = '0;
    end else if (bus.wb_en && (starve_cnt != STV_W'(STARVE_LIMIT))) begin
      starve_next = starve_cnt + 1'b1;
    end
  end

  // Starvation counter and stall FSM; looking at starve_next makes stall_req
  // rise on the cycle right after the counter reaches the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt    <= '0;
      state         <= IDLE;
      bus.stall_req <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      case (state)
        IDLE: begin
          if (starve_next == STV_W'(STARVE_LIMIT)) begin
            state         <= STALL;
            bus.stall_req <= 1'b1;
          end
        end
        STALL: begin
          if (pop) begin
            state         <= IDLE;
            bus.stall_req <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
